// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Two-stage pipeline: grant + registered mux select, then capture of the mux output.
module rf_read_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ-1:0]      lock,
  output logic [AW-1:0]        mux_sel,
  input  logic [DW-1:0]        mux_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy
);

  logic [NREQ-1:0] gnt_r;
  logic [AW-1:0]   mux_sel_r;
  logic [IDW-1:0]  ptr_r;
  logic            lock_cnt_r;
  logic            s1_valid_r;
  logic [IDW-1:0]  id1_r;
  logic            zero1_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [DW-1:0]   rsp_data_r;
  logic            busy_r;

  logic [NREQ-1:0] lock_hit_s;
  logic            force_s;
  logic            any_s;
  logic            found_s;
  logic [IDW-1:0]  rr_win_s;
  logic [IDW-1:0]  lock_win_s;
  logic [IDW-1:0]  win_s;
  logic [AW-1:0]   win_addr_s;
  logic [NREQ-1:0] gnt_nxt_s;

  // Winner selection: a held lock from the previous grant overrides round-robin once
  always_comb begin
    lock_hit_s = gnt_r & req & lock;
    force_s    = (lock_cnt_r == 1'b0) && (|lock_hit_s);
    any_s      = |req;
    found_s    = 1'b0;
    rr_win_s   = {IDW{1'b0}};
    lock_win_s = {IDW{1'b0}};
    // First pass covers indices above the pointer, second pass wraps to 0..ptr.
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i] && (i > int'(ptr_r))) begin
        found_s  = 1'b1;
        rr_win_s = IDW'(i);
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req[i]) begin
        found_s  = 1'b1;
        rr_win_s = IDW'(i);
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (lock_hit_s[i]) begin
        lock_win_s = IDW'(i);
      end else begin
        lock_win_s = lock_win_s;
      end
    end
    if (force_s) begin
      win_s = lock_win_s;
    end else begin
      win_s = rr_win_s;
    end
  end

  // Decode the winner into its address slice and one-hot grant
  always_comb begin
    win_addr_s = {AW{1'b0}};
    gnt_nxt_s  = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (any_s && (win_s == IDW'(i))) begin
        win_addr_s   = addr[i*AW +: AW];
        gnt_nxt_s[i] = 1'b1;
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Stage 1: grant, select register, pointer and lock counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_r      <= {NREQ{1'b0}};
      mux_sel_r  <= {AW{1'b0}};
      ptr_r      <= IDW'(NREQ - 1);
      lock_cnt_r <= 1'b0;
      s1_valid_r <= 1'b0;
      id1_r      <= {IDW{1'b0}};
      zero1_r    <= 1'b0;
    end else begin
      gnt_r      <= gnt_nxt_s;
      s1_valid_r <= any_s;
      if (any_s) begin
        mux_sel_r  <= win_addr_s;
        ptr_r      <= win_s;
        lock_cnt_r <= force_s;
        id1_r      <= win_s;
        zero1_r    <= (win_addr_s == {AW{1'b0}});
      end else begin
        mux_sel_r  <= mux_sel_r;
        ptr_r      <= ptr_r;
        lock_cnt_r <= lock_cnt_r;
        id1_r      <= id1_r;
        zero1_r    <= zero1_r;
      end
    end
  end

  // Stage 2: capture the settled mux output; register 0 always reads as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_data_r  <= {DW{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      rsp_valid_r <= s1_valid_r;
      busy_r      <= any_s | s1_valid_r;
      if (s1_valid_r) begin
        rsp_id_r   <= id1_r;
        rsp_data_r <= zero1_r ? {DW{1'b0}} : mux_data;
      end else begin
        rsp_id_r   <= rsp_id_r;
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign gnt       = gnt_r;
  assign mux_sel   = mux_sel_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule
